// File: rtl/ram_mp_pkg.sv
// Shared constants for the multi-port byte-addressed RAM: byte width, access size
// codes, clear-FSM states and the access-size helper.
package ram_mp_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int BYTE_WIDTH   = 8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    // Number of bytes touched by an access; size code 3 behaves as a word.
    function automatic int size_bytes(input logic [1:0] size, input int lanes);
        int n;
        case (size)
            SIZE_B:  n = 1;
            SIZE_H:  n = 2;
            default: n = 4;
        endcase
        return (n > lanes) ? lanes : n;
    endfunction

endpackage

// File: rtl/ram_mp_lane.sv
// One byte lane of the RAM: a single write port (shared by clear and normal writes)
// and READ_PORTS asynchronous read ports, each with write-first bypass.
module ram_mp_lane
    import ram_mp_pkg::*;
#(
    parameter int ROW_BITS   = 14,
    parameter int READ_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ROW_BITS-1:0]            waddr,
    input  logic [BYTE_WIDTH-1:0]          wdata,
    input  logic [READ_PORTS*ROW_BITS-1:0] raddr,
    output logic [READ_PORTS*BYTE_WIDTH-1:0] rdata
);

    localparam int ROWS = 2 ** ROW_BITS;

    logic [BYTE_WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
            logic [ROW_BITS-1:0] ra;
            assign ra = raddr[gi*ROW_BITS +: ROW_BITS];
            // Same row written this cycle: return the incoming byte.
            assign rdata[gi*BYTE_WIDTH +: BYTE_WIDTH] = (we && (waddr == ra)) ? wdata : mem[ra];
        end
    endgenerate

endmodule

// File: rtl/ram_mp.sv
// Multi-port byte-addressed RAM: N read ports, one write port, any alignment with
// wrap-around, registered extended reads, and a post-reset clear sequence.
module ram_mp
    import ram_mp_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int ADDR_WIDTH = 16,
    parameter int READ_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    input  logic [READ_PORTS-1:0]        rd_req,
    input  logic [READ_PORTS*XLEN-1:0]   rd_addr,
    input  logic [READ_PORTS*2-1:0]      rd_size,
    input  logic [READ_PORTS-1:0]        rd_signed,
    output logic [READ_PORTS-1:0]        rd_valid,
    output logic [READ_PORTS*XLEN-1:0]   rd_data,
    input  logic                         wr_en,
    input  logic [XLEN-1:0]              wr_addr,
    input  logic [1:0]                   wr_size,
    input  logic [XLEN-1:0]              wr_data
);

    localparam int LANES     = XLEN / BYTE_WIDTH;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int LIDX_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int ROW_BITS  = ADDR_WIDTH - LANE_BITS;

    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
    localparam logic [ROW_BITS-1:0]   LAST_ROW  = '1;

    state_t              state_reg, state_next;
    logic [ROW_BITS-1:0] row_reg, row_next;
    logic                clearing;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_CLEAR;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        clearing   = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                clearing = 1'b1;
                row_next = row_reg + ROW_BITS'(1);
                if (row_reg == LAST_ROW) begin
                    state_next = S_READY;
                end
            end
            default: ;
        endcase
    end

    assign ready = (state_reg == S_READY);

    logic [ADDR_WIDTH-1:0] wa;
    logic [ADDR_WIDTH-1:0] wn;
    assign wa = wr_addr[ADDR_WIDTH-1:0];
    assign wn = ADDR_WIDTH'(size_bytes(wr_size, LANES));

    logic [READ_PORTS*BYTE_WIDTH-1:0] lane_rdata [LANES];
    logic [XLEN-1:0]                  port_ext   [READ_PORTS];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [ADDR_WIDTH-1:0] LANE_ID = ADDR_WIDTH'(gi);

            // Byte index k within the access that falls into this lane, and its address.
            logic [ADDR_WIDTH-1:0]           wk, wba;
            logic                            we;
            logic [ROW_BITS-1:0]             waddr;
            logic [BYTE_WIDTH-1:0]           wdata;
            logic [READ_PORTS*ROW_BITS-1:0]  raddr;
            logic [READ_PORTS*BYTE_WIDTH-1:0] rdata;

            assign wk    = (LANE_ID - wa) & LANE_MASK;
            assign wba   = wa + wk;
            assign we    = clearing || (ready && wr_en && (wk < wn));
            assign waddr = clearing ? row_reg : wba[ADDR_WIDTH-1:LANE_BITS];
            assign wdata = clearing ? '0 : wr_data[wk*BYTE_WIDTH +: BYTE_WIDTH];

            for (genvar gp = 0; gp < READ_PORTS; gp++) begin : g_rp
                logic [ADDR_WIDTH-1:0] ra, rk, rba;
                assign ra = rd_addr[gp*XLEN +: ADDR_WIDTH];
                assign rk = (LANE_ID - ra) & LANE_MASK;
                assign rba = ra + rk;
                assign raddr[gp*ROW_BITS +: ROW_BITS] = rba[ADDR_WIDTH-1:LANE_BITS];
            end

            ram_mp_lane #(
                .ROW_BITS   (ROW_BITS),
                .READ_PORTS (READ_PORTS)
            ) u_lane (
                .clk   (clk),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .raddr (raddr),
                .rdata (rdata)
            );

            assign lane_rdata[gi] = rdata;
        end

        for (genvar gp = 0; gp < READ_PORTS; gp++) begin : g_port
            logic [ADDR_WIDTH-1:0] ra, rn;
            logic [LIDX_W-1:0]     sign_lane;
            logic                  sign_bit;
            logic [XLEN-1:0]       ext;
            logic                  unused_hi;

            assign ra        = rd_addr[gp*XLEN +: ADDR_WIDTH];
            assign rn        = ADDR_WIDTH'(size_bytes(rd_size[gp*2 +: 2], LANES));
            assign sign_lane = LIDX_W'((ra + rn - ADDR_WIDTH'(1)) & LANE_MASK);
            assign sign_bit  = rd_signed[gp] & lane_rdata[sign_lane][gp*BYTE_WIDTH + BYTE_WIDTH - 1];
            assign unused_hi = ^rd_addr[gp*XLEN + ADDR_WIDTH +: XLEN - ADDR_WIDTH];

            // Rotate lanes back into access order, then extend above byte n-1.
            always_comb begin
                ext = '0;
                for (int k = 0; k < LANES; k++) begin
                    if (ADDR_WIDTH'(k) < rn) begin
                        ext[k*BYTE_WIDTH +: BYTE_WIDTH] =
                            lane_rdata[LIDX_W'((ra + ADDR_WIDTH'(k)) & LANE_MASK)][gp*BYTE_WIDTH +: BYTE_WIDTH];
                    end else begin
                        ext[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{sign_bit}};
                    end
                end
            end

            assign port_ext[gp] = ext;
        end
    endgenerate

    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_addr[XLEN-1:ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            for (int p = 0; p < READ_PORTS; p++) begin
                rd_valid[p] <= ready & rd_req[p];
                if (ready && rd_req[p]) begin
                    rd_data[p*XLEN +: XLEN] <= port_ext[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_mp.sv
// Self-checking bench for ram_mp: constant vector table, hand sequences for collision,
// clear and reset, plus randomized traffic against a byte-array reference model.
module tb_ram_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [1:0]  rd_req;
    logic [63:0] rd_addr;
    logic [3:0]  rd_size;
    logic [1:0]  rd_signed;
    logic [1:0]  rd_valid;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;

    int passed = 0;
    int total  = 0;

    ram_mp #(.XLEN(32), .ADDR_WIDTH(16), .READ_PORTS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_size   (rd_size),
        .rd_signed (rd_signed),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_size   (wr_size),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Reference model: flat byte array, 64 KiB.
    logic [7:0] mem_m [65536];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 65536; i++) mem_m[i] = 8'h00;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        for (int k = 0; k < nbytes(s); k++)
            mem_m[(int'(a[15:0]) + k) % 65536] = d[8*k +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] s, input logic sgn);
        logic [63:0] v;
        logic [63:0] mask;
        int n;
        n = nbytes(s);
        v = 64'd0;
        for (int k = 0; k < n; k++)
            v = v | (64'(mem_m[(int'(a[15:0]) + k) % 65536]) << (8*k));
        mask = (64'd1 << (8*n)) - 64'd1;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = '0; wr_en = 1'b0;
    endtask

    // Counts cycles from reset release until ready; optionally injects requests mid-clear.
    task automatic wait_ready(input bit inject);
        int cycles;
        cycles = 0;
        while (!ready && cycles < 20000) begin
            if (inject && cycles == 2000) begin
                rd_req = 2'b11; rd_addr = {32'h10, 32'h10}; rd_size = 4'b1010; rd_signed = 2'b00;
                wr_en = 1'b1; wr_addr = 32'h10; wr_size = 2'd2; wr_data = 32'hFFFFFFFF;
            end
            if (inject && cycles == 2004) idle();
            step();
            cycles++;
            if (inject && cycles > 2000 && cycles <= 2004)
                check("clear_rd_valid", 32'(rd_valid), 32'd0);
        end
        idle();
        $display("ready after %0d cycles", cycles);
        check("clear_cycles", cycles, 32'd16384);
    endtask

    typedef struct {
        bit          is_wr;
        int          port;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] val;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_data [2];
    logic [31:0] ra;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [15:0] base;
        base = ($urandom_range(0, 1) != 0) ? 16'hFFF0 : 16'h0300;
        a[31:16] = 16'($urandom);
        a[15:0]  = base + 16'($urandom_range(0, 31));
        return a;
    endfunction

    initial begin
        rst = 1'b0;
        rd_req = '0; rd_addr = '0; rd_size = '0; rd_signed = '0;
        wr_en = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
        model_clear();
        repeat (3) step();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_data0", rd_data[31:0], 32'd0);
        check("reset_data1", rd_data[63:32], 32'd0);

        // Release reset, count clear, and check that mid-clear requests are ignored.
        rst = 1'b1;
        wait_ready(1'b1);

        // Word read at 0x1234 after clear, latency one.
        rd_req = 2'b01; rd_addr[31:0] = 32'h1234; rd_size[1:0] = 2'd2; rd_signed = 2'b00;
        step();
        idle();
        check("t1_valid", 32'(rd_valid[0]), 32'd1);
        check("t1_data", rd_data[31:0], 32'h0);
        step();
        check("t1_valid_drop", 32'(rd_valid[0]), 32'd0);

        // Write ignored during clear must not have landed.
        rd_req = 2'b01; rd_addr[31:0] = 32'h10; rd_size[1:0] = 2'd2;
        step();
        idle();
        check("t5_after_clear", rd_data[31:0], 32'h0);

        vecs.push_back('{1'b1, 0, 32'h0000_0100, 2'd2, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 0, 32'h0000_0101, 2'd0, 1'b1, 32'hFFFFFFBE});
        vecs.push_back('{1'b0, 1, 32'h0000_0101, 2'd0, 1'b0, 32'h000000BE});
        vecs.push_back('{1'b0, 0, 32'h0000_0102, 2'd1, 1'b1, 32'hFFFFDEAD});
        vecs.push_back('{1'b0, 1, 32'h0000_0100, 2'd2, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 0, 32'h0000_0100, 2'd3, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1, 32'h0000_0100, 2'd1, 1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b1, 0, 32'h0000_FFFE, 2'd2, 1'b0, 32'h11223344});
        vecs.push_back('{1'b0, 0, 32'h0000_FFFE, 2'd2, 1'b0, 32'h11223344});
        vecs.push_back('{1'b0, 1, 32'h0000_0000, 2'd0, 1'b0, 32'h00000022});
        vecs.push_back('{1'b0, 0, 32'h0000_0001, 2'd0, 1'b0, 32'h00000011});
        vecs.push_back('{1'b0, 0, 32'hABCD_FFFF, 2'd0, 1'b1, 32'h00000033});
        vecs.push_back('{1'b0, 1, 32'h0000_FFFF, 2'd1, 1'b1, 32'h00002233});
        vecs.push_back('{1'b1, 0, 32'h0000_0200, 2'd2, 1'b0, 32'hAAAAAAAA});
        vecs.push_back('{1'b0, 0, 32'h0000_0200, 2'd0, 1'b1, 32'hFFFFFFAA});

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                wr_en = 1'b1; wr_addr = vecs[i].addr; wr_size = vecs[i].size; wr_data = vecs[i].val;
                step();
                idle();
                model_write(vecs[i].addr, vecs[i].size, vecs[i].val);
            end else begin
                rd_req[vecs[i].port] = 1'b1;
                rd_addr[vecs[i].port*32 +: 32] = vecs[i].addr;
                rd_size[vecs[i].port*2 +: 2] = vecs[i].size;
                rd_signed[vecs[i].port] = vecs[i].sgn;
                step();
                idle();
                $display("vec %0d port %0d addr %h size %0d -> %h", i, vecs[i].port, vecs[i].addr,
                         vecs[i].size, rd_data[vecs[i].port*32 +: 32]);
                check($sformatf("vec%0d_valid", i), 32'(rd_valid[vecs[i].port]), 32'd1);
                check($sformatf("vec%0d_data", i), rd_data[vecs[i].port*32 +: 32], vecs[i].val);
            end
        end

        // Same-cycle write/read collision with partial overlap.
        wr_en = 1'b1; wr_addr = 32'h0201; wr_size = 2'd1; wr_data = 32'h0000_5566;
        rd_req = 2'b11; rd_addr = {32'h0203, 32'h0200}; rd_size = {2'd0, 2'd2}; rd_signed = 2'b00;
        step();
        idle();
        model_write(32'h0201, 2'd1, 32'h5566);
        check("t4_port0", rd_data[31:0], 32'hAA5566AA);
        check("t4_port1", rd_data[63:32], 32'h000000AA);
        check("t4_valid", 32'(rd_valid), 32'd3);
        rd_req = 2'b01; rd_addr[31:0] = 32'h0200; rd_size[1:0] = 2'd2;
        step();
        idle();
        check("t4_readback", rd_data[31:0], 32'hAA5566AA);

        // Randomized traffic against the model; write-first means update before reading.
        exp_data[0] = rd_data[31:0];
        exp_data[1] = rd_data[63:32];
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 1) != 0);
            wr_addr = rand_addr();
            wr_size = 2'($urandom);
            wr_data = $urandom;
            for (int p = 0; p < 2; p++) begin
                rd_req[p] = ($urandom_range(0, 2) != 0);
                ra = rand_addr();
                if (p == 1 && $urandom_range(0, 3) == 0) ra = rd_addr[31:0];
                rd_addr[p*32 +: 32] = ra;
                rd_size[p*2 +: 2] = 2'($urandom);
                rd_signed[p] = 1'($urandom);
            end
            if (wr_en) model_write(wr_addr, wr_size, wr_data);
            for (int p = 0; p < 2; p++)
                if (rd_req[p])
                    exp_data[p] = model_read(rd_addr[p*32 +: 32], rd_size[p*2 +: 2], rd_signed[p]);
            step();
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rand%0d_p%0d_valid", i, p), 32'(rd_valid[p]), 32'(rd_req[p]));
                check($sformatf("rand%0d_p%0d_data", i, p), rd_data[p*32 +: 32], exp_data[p]);
            end
        end
        idle();
        step();

        // Reset mid-operation with a pending read.
        rd_req = 2'b01; rd_addr[31:0] = 32'h0100; rd_size[1:0] = 2'd2; rd_signed = 2'b00;
        step();
        check("t6_pre_data", rd_data[31:0], model_read(32'h0100, 2'd2, 1'b0));
        #2 rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(rd_valid), 32'd0);
        check("t6_async_data", rd_data[31:0], 32'd0);
        check("t6_async_ready", 32'(ready), 32'd0);
        step();
        check("t6_held_valid", 32'(rd_valid), 32'd0);
        idle();
        rst = 1'b1;
        model_clear();
        wait_ready(1'b0);
        rd_req = 2'b01; rd_addr[31:0] = 32'h0100; rd_size[1:0] = 2'd2;
        step();
        idle();
        check("t6_cleared", rd_data[31:0], model_read(32'h0100, 2'd2, 1'b0));
        check("t6_cleared_const", rd_data[31:0], 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
